// File: rtl/layer_sequencer.sv
// Layer sequencer: broadcasts an input vector to a layer of neurons, collects
// one result per neuron, then streams the results downstream in neuron order.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for the first beat of a vector
// ST_FEED  | accepting beats, broadcasting them to the neurons
// ST_WAIT  | all beats sent, waiting for neuron results (bounded)
// ST_DRAIN | streaming buffered results downstream
module layer_sequencer #(
    parameter int numWeight     = 784,
    parameter int numNeuron     = 30,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [dataWidth-1:0]           s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [dataWidth-1:0]           nInput,
    output logic                           nInputValid,
    input  logic [numNeuron*dataWidth-1:0] nOutput,
    input  logic [numNeuron-1:0]           nOutputValid,
    output logic [dataWidth-1:0]           m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic                           busy,
    output logic                           err_timeout,
    output logic                           err_unexpected,
    input  logic                           clr_err
);

    localparam int IW = $clog2(numWeight);
    localparam int OW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam int WW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_WAIT, ST_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IW-1:0]         r_icnt;
    logic [WW-1:0]         r_wcnt;
    logic [OW-1:0]         r_ocnt;
    logic [OW-1:0]         w_ocnt_inc;
    logic [numNeuron-1:0]  r_mask;
    logic [dataWidth-1:0]  r_buf [numNeuron];
    logic [dataWidth-1:0]  r_n_input;
    logic                  r_n_valid;
    logic [dataWidth-1:0]  r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_err_timeout;
    logic                  r_err_unexpected;

    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_collect;
    logic [numNeuron-1:0]  w_new;
    logic [numNeuron-1:0]  w_dup;
    logic [numNeuron-1:0]  w_mask_next;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_xfer_last;

    assign w_accept    = s_valid & s_ready;
    assign w_last_beat = w_accept && (r_state == ST_FEED) && (r_icnt == IW'(numWeight - 1));
    assign w_collect   = (r_state == ST_FEED) || (r_state == ST_WAIT);
    // Outside FEED/WAIT every neuron valid is unexpected; inside, only repeats are.
    assign w_new       = w_collect ? (nOutputValid & ~r_mask) : '0;
    assign w_dup       = w_collect ? (nOutputValid & r_mask) : nOutputValid;
    assign w_mask_next = r_mask | w_new;
    assign w_complete  = w_collect && (&w_mask_next);
    // Completion in the same cycle as the last WAIT cycle suppresses the timeout.
    assign w_timeout   = (r_state == ST_WAIT) && (r_wcnt == WW'(timeoutCycles - 1)) && !w_complete;
    assign w_xfer_last = (r_state == ST_DRAIN) && r_m_valid && m_ready && r_m_last;
    assign w_ocnt_inc  = r_ocnt + OW'(1);

    assign nInput         = r_n_input;
    assign nInputValid    = r_n_valid;
    assign m_data         = r_m_data;
    assign m_valid        = r_m_valid;
    assign m_last         = r_m_last;
    assign err_timeout    = r_err_timeout;
    assign err_unexpected = r_err_unexpected;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode plus state-derived handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (w_accept) w_state_next = ST_FEED;
            end
            ST_FEED: begin
                s_ready = 1'b1;
                if (w_complete)       w_state_next = ST_DRAIN;
                else if (w_last_beat) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_complete || w_timeout) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_xfer_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Input broadcast, beat counter and WAIT cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n_input <= '0;
            r_n_valid <= 1'b0;
            r_icnt    <= '0;
            r_wcnt    <= '0;
        end else begin
            r_n_valid <= w_accept;
            if (w_accept) begin
                r_n_input <= s_data;
                if (r_state == ST_IDLE)               r_icnt <= IW'(1);
                else if (r_icnt == IW'(numWeight - 1)) r_icnt <= '0;
                else                                   r_icnt <= r_icnt + IW'(1);
            end
            if (r_state == ST_WAIT) r_wcnt <= r_wcnt + WW'(1);
            else                    r_wcnt <= '0;
        end
    end

    // Result capture: first valid per neuron wins; buffers clear at vector start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask <= '0;
            for (int i = 0; i < numNeuron; i++) r_buf[i] <= '0;
        end else if ((r_state == ST_IDLE) && w_accept) begin
            r_mask <= '0;
            for (int i = 0; i < numNeuron; i++) r_buf[i] <= '0;
        end else if (w_collect) begin
            r_mask <= w_mask_next;
            for (int i = 0; i < numNeuron; i++)
                if (w_new[i]) r_buf[i] <= nOutput[i*dataWidth +: dataWidth];
        end
    end

    // Downstream stream: first beat loads one cycle into DRAIN, then advances on handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ocnt    <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            if (!r_m_valid) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_buf[r_ocnt];
                r_m_last  <= (r_ocnt == OW'(numNeuron - 1));
            end else if (m_ready) begin
                if (r_m_last) begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_ocnt    <= '0;
                end else begin
                    r_ocnt   <= w_ocnt_inc;
                    r_m_data <= r_buf[w_ocnt_inc];
                    r_m_last <= (w_ocnt_inc == OW'(numNeuron - 1));
                end
            end
        end else begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_ocnt    <= '0;
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_timeout    <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else begin
            if (w_timeout)    r_err_timeout <= 1'b1;
            else if (clr_err) r_err_timeout <= 1'b0;
            if (|w_dup)       r_err_unexpected <= 1'b1;
            else if (clr_err) r_err_unexpected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 4-beat, 3-neuron configuration.
module tb_layer_sequencer;

    localparam int NW = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    nInput;
    logic             nInputValid;
    logic [NN*DW-1:0] nOutput = '0;
    logic [NN-1:0]    nOutputValid = '0;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_last;
    logic             busy;
    logic             err_timeout;
    logic             err_unexpected;
    logic             clr_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    layer_sequencer #(.numWeight(NW), .numNeuron(NN), .dataWidth(DW), .timeoutCycles(TO)) u_dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .nInput(nInput), .nInputValid(nInputValid),
        .nOutput(nOutput), .nOutputValid(nOutputValid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err_timeout(err_timeout), .err_unexpected(err_unexpected),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic feed4(input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = base + DW'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse(input logic [NN-1:0] v, input logic [NN*DW-1:0] d);
        nOutputValid = v;
        nOutput      = d;
        @(negedge clk);
        nOutputValid = '0;
    endtask

    task automatic drain3(input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        logic [DW-1:0] exp_d [3];
        int n;
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2;
        n = 0;
        m_ready = 1'b1;
        for (int k = 0; k < 40 && n < 3; k++) begin
            if (m_valid) begin
                chk("m_data", 32'(m_data), 32'(exp_d[n]));
                chk("m_last", 32'(m_last), 32'(n == 2));
                n++;
            end
            @(negedge clk);
        end
        if (n < 3) chk("drain_beats", n, 3);
        chk("m_valid_after_drain", 32'(m_valid), 0);
        chk("busy_after_drain", 32'(busy), 0);
        m_ready = 1'b0;
    endtask

    initial begin
        int xfers;
        logic [DW-1:0] held;

        // Reset state
        #12;
        chk("rst_nInputValid", 32'(nInputValid), 0);
        chk("rst_nInput", 32'(nInput), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Broadcast of four beats, one cycle late, then input closed
        chk("bc_pre_valid", 32'(nInputValid), 0);
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            @(negedge clk);
            chk("bc_valid", 32'(nInputValid), 1);
            chk("bc_data", 32'(nInput), i);
        end
        chk("bc_s_ready_closed", 32'(s_ready), 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("bc_valid_drop", 32'(nInputValid), 0);
        chk("bc_busy", 32'(busy), 1);

        // Out-of-order neuron results drained in neuron order
        pulse(3'b100, {16'h000C, 16'h0000, 16'h0000});
        pulse(3'b001, {16'h0000, 16'h0000, 16'h000A});
        pulse(3'b010, {16'h0000, 16'h000B, 16'h0000});
        drain3(16'h000A, 16'h000B, 16'h000C);
        chk("ooo_err_u", 32'(err_unexpected), 0);

        // All results at once, downstream ready toggling 1,0,1,0,1
        feed4(16'h0100);
        pulse(3'b111, {16'h0033, 16'h0022, 16'h0011});
        for (int k = 0; k < 10 && !m_valid; k++) @(negedge clk);
        chk("bp_m_valid_seen", 32'(m_valid), 1);
        xfers = 0;
        held  = '0;
        for (int k = 0; k < 5; k++) begin
            m_ready = ~k[0];
            if (k[0] == 1'b0 && k > 0) chk("bp_held", 32'(m_data), 32'(held));
            if (m_valid && m_ready) begin
                chk("bp_data", 32'(m_data), 32'(16'h0011 * (xfers + 1)));
                xfers++;
            end
            held = m_data;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("bp_xfers", xfers, 3);
        chk("bp_m_valid_end", 32'(m_valid), 0);

        // Completion on the final WAIT cycle wins over timeout
        feed4(16'h0200);
        pulse(3'b011, {16'h0000, 16'h0042, 16'h0041});
        repeat (14) @(negedge clk);
        pulse(3'b100, {16'h0043, 16'h0000, 16'h0000});
        chk("edge_no_timeout", 32'(err_timeout), 0);
        drain3(16'h0041, 16'h0042, 16'h0043);

        // Timeout after 16 WAIT cycles, missing neuron reads zero
        feed4(16'h0300);
        pulse(3'b011, {16'h0000, 16'h0052, 16'h0051});
        repeat (14) @(negedge clk);
        chk("to_not_yet", 32'(err_timeout), 0);
        @(negedge clk);
        chk("to_set", 32'(err_timeout), 1);
        drain3(16'h0051, 16'h0052, 16'h0000);
        chk("to_sticky", 32'(err_timeout), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("to_cleared", 32'(err_timeout), 0);

        // Duplicate valid keeps the first captured value
        feed4(16'h0400);
        pulse(3'b010, {16'h0000, 16'h0061, 16'h0000});
        pulse(3'b010, {16'h0000, 16'h0099, 16'h0000});
        chk("dup_err_u", 32'(err_unexpected), 1);
        pulse(3'b101, {16'h0062, 16'h0000, 16'h0060});
        drain3(16'h0060, 16'h0061, 16'h0062);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("dup_cleared", 32'(err_unexpected), 0);

        // Neuron valid while IDLE is flagged and ignored
        pulse(3'b100, {16'h0077, 16'h0000, 16'h0000});
        chk("idle_err_u", 32'(err_unexpected), 1);
        chk("idle_busy", 32'(busy), 0);

        // Reset mid-vector, then a clean vector from beat zero
        s_valid = 1'b1; s_data = 16'h0071;
        @(negedge clk);
        s_data = 16'h0072;
        @(negedge clk);
        s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_nInput", 32'(nInput), 0);
        chk("mid_rst_nInputValid", 32'(nInputValid), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err_u", 32'(err_unexpected), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h0081 + DW'(i);
            @(negedge clk);
            if (i == 1) chk("post_rst_still_open", 32'(s_ready), 1);
        end
        s_valid = 1'b0;
        chk("post_rst_closed", 32'(s_ready), 0);
        chk("post_rst_last_in", 32'(nInput), 32'h0084);
        pulse(3'b111, {16'h0093, 16'h0092, 16'h0091});
        drain3(16'h0091, 16'h0092, 16'h0093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
